// File: rtl/csa_acc_pkg.sv
// -----------------------------------------------------------------------------
// csa_acc_pkg
// Shared types and helpers for the carry-save streaming accumulator.
//   state_t : ACCUM (folding operands), RESOLVE (chunked carry propagation),
//             DONE (result presented on the output handshake)
//   n_res() : number of resolve cycles for a given width and chunk size
// Optional feature macro used by this slice: CSA_ACC_OVF_EN.
// -----------------------------------------------------------------------------
package csa_acc_pkg;

    typedef enum logic [1:0] {
        ACCUM   = 2'd0,
        RESOLVE = 2'd1,
        DONE    = 2'd2
    } state_t;

    // Resolve cycles needed to turn the S/C pair into a binary result.
    function automatic int n_res(input int width, input int chunk);
        return width / chunk;
    endfunction

endpackage

// File: rtl/csa_accumulator_if.sv
// -----------------------------------------------------------------------------
// csa_accumulator_if
// Operand stream in, frame result out, plus the busy indicator.
//   in_valid/in_ready/in_data/in_last    : operand stream (master -> slave)
//   out_valid/out_ready/out_data         : result stream  (slave -> master)
//   busy                                 : slave status
//   out_ovf                              : frame overflow, only with CSA_ACC_OVF_EN
// master = operand source / result sink, slave = accumulator.
// -----------------------------------------------------------------------------
interface csa_accumulator_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             busy;
`ifdef CSA_ACC_OVF_EN
    logic             out_ovf;

    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_data, busy, out_ovf
    );
    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_data, busy, out_ovf
    );
`else
    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_data, busy
    );
    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_data, busy
    );
`endif
endinterface

// File: rtl/carry_save_adder.sv
// -----------------------------------------------------------------------------
// carry_save_adder
// Bitwise 3:2 compressor: in_1 + in_2 + c_in == sum + (c_out << 1).
//   in_1, in_2, c_in : three WIDTH-bit addends
//   sum              : per-bit XOR
//   c_out            : per-bit majority (carry, not yet shifted)
// -----------------------------------------------------------------------------
module carry_save_adder #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] in_1,
    input  logic [WIDTH-1:0] in_2,
    input  logic [WIDTH-1:0] c_in,
    output logic [WIDTH-1:0] sum,
    output logic [WIDTH-1:0] c_out
);
    assign sum   = in_1 ^ in_2 ^ c_in;
    assign c_out = (in_1 & in_2) | (in_1 & c_in) | (in_2 & c_in);
endmodule

// File: rtl/csa_accumulator.sv
// -----------------------------------------------------------------------------
// csa_accumulator
// Streaming multi-operand accumulator. Operands are folded into a redundant
// S/C pair with no carry propagation; on the last beat of a frame the pair is
// resolved CHUNK bits per cycle and the binary result (mod 2^WIDTH) is offered
// on the output handshake.
//   clk : rising-edge clock
//   rst : synchronous, active-high reset (discards any partial frame)
//   bus : csa_accumulator_if.slave (operand stream, result stream, busy)
// Optional: define CSA_ACC_OVF_EN to add bus.out_ovf, a sticky flag that is 1
// when the true unsigned frame sum does not fit in WIDTH bits.
// -----------------------------------------------------------------------------
module csa_accumulator
    import csa_acc_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CHUNK = 4
) (
    input  logic              clk,
    input  logic              rst,
    csa_accumulator_if.slave  bus
);
    localparam int N_RES = n_res(WIDTH, CHUNK);
    // Counts 0..N_RES: N_RES resolve cycles plus one settle cycle before DONE.
    localparam int IDX_W = $clog2(N_RES + 1);

    if (WIDTH % CHUNK != 0) begin : g_width_check
        $error("csa_accumulator: WIDTH must be a multiple of CHUNK");
    end

    state_t             state, state_nx;
    logic [WIDTH-1:0]   s, c, r;
    logic [WIDTH-1:0]   csa_sum, csa_cout;
    logic [IDX_W-1:0]   res_idx;
    logic               res_cy;
    logic [CHUNK-1:0]   s_chunk, c_chunk;
    logic [CHUNK:0]     chunk_sum;
    logic               accept, handshake, last_chunk, res_done;

    carry_save_adder #(.WIDTH(WIDTH)) u_csa (
        .in_1  (s),
        .in_2  (c),
        .c_in  (bus.in_data),
        .sum   (csa_sum),
        .c_out (csa_cout)
    );

    assign accept     = (state == ACCUM) && bus.in_valid;
    assign handshake  = (state == DONE) && bus.out_ready;
    assign last_chunk = (res_idx == IDX_W'(N_RES - 1));
    assign res_done   = (res_idx == IDX_W'(N_RES));

    // Chunk selector for the resolver; during the settle cycle nothing matches
    // and the sum is never written back.
    always_comb begin
        // NOTE: every comb output gets a default first so no latch is inferred.
        s_chunk = '0;
        c_chunk = '0;
        for (int k = 0; k < N_RES; k++) begin
            if (res_idx == IDX_W'(k)) begin
                s_chunk = s[k*CHUNK +: CHUNK];
                c_chunk = c[k*CHUNK +: CHUNK];
            end
        end
        chunk_sum = {1'b0, s_chunk} + {1'b0, c_chunk} + {{CHUNK{1'b0}}, res_cy};
    end

    // FSM: state register
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (rst) state <= ACCUM;
        else     state <= state_nx;
    end

    // FSM: next-state logic
    always_comb begin
        state_nx = state;
        unique case (state)
            ACCUM:   if (accept && bus.in_last) state_nx = RESOLVE;
            RESOLVE: if (res_done)              state_nx = DONE;
            DONE:    if (handshake)             state_nx = ACCUM;
            default:                            state_nx = ACCUM;
        endcase
    end

    // FSM: outputs (state and registered datapath only)
    always_comb begin
        bus.in_ready  = (state == ACCUM);
        bus.out_valid = (state == DONE);
        bus.busy      = (state != ACCUM) || ((s + c) != '0);
    end

    assign bus.out_data = r;

`ifdef CSA_ACC_OVF_EN
    logic ovf;
    assign bus.out_ovf = ovf;
`else
    logic unused_cout_msb;
    assign unused_cout_msb = csa_cout[WIDTH-1];
`endif

    // Datapath
    always_ff @(posedge clk) begin
        if (rst) begin
            s       <= '0;
            c       <= '0;
            r       <= '0;
            res_idx <= '0;
            res_cy  <= 1'b0;
`ifdef CSA_ACC_OVF_EN
            ovf     <= 1'b0;
`endif
        end else begin
            unique case (state)
                ACCUM: begin
                    if (accept) begin
                        s <= csa_sum;
                        // Carry MSB falls off the top: the sum is modulo 2^WIDTH.
                        c <= {csa_cout[WIDTH-2:0], 1'b0};
`ifdef CSA_ACC_OVF_EN
                        ovf <= ovf | csa_cout[WIDTH-1];
`endif
                        if (bus.in_last) begin
                            res_idx <= '0;
                            res_cy  <= 1'b0;
                        end
                    end
                end
                RESOLVE: begin
                    for (int k = 0; k < N_RES; k++) begin
                        if (res_idx == IDX_W'(k)) r[k*CHUNK +: CHUNK] <= chunk_sum[CHUNK-1:0];
                    end
                    if (!res_done) begin
                        res_cy  <= chunk_sum[CHUNK];
                        res_idx <= res_idx + 1'b1;
                    end
`ifdef CSA_ACC_OVF_EN
                    if (last_chunk) ovf <= ovf | chunk_sum[CHUNK];
`endif
                end
                DONE: begin
                    if (handshake) begin
                        s <= '0;
                        c <= '0;
`ifdef CSA_ACC_OVF_EN
                        ovf <= 1'b0;
`endif
                    end
                end
                default: ;
            endcase
        end
    end

`ifndef CSA_ACC_OVF_EN
    logic unused_last_chunk;
    assign unused_last_chunk = last_chunk;
`endif

endmodule

// File: tb/tb_csa_accumulator.sv
// -----------------------------------------------------------------------------
// tb_csa_accumulator
// Directed bench for csa_accumulator (WIDTH=8, CHUNK=4). A frame-level model
// sums accepted operands with plain integer arithmetic and queues the expected
// result; a negedge monitor compares every valid output cycle against it.
// Honours CSA_ACC_OVF_EN for the out_ovf port.
// -----------------------------------------------------------------------------
module tb_csa_accumulator;
    localparam int WIDTH = 8;
    localparam int CHUNK = 4;
    localparam int N_RES = WIDTH / CHUNK;
    // Counted from the negedge before the accepting edge: the accepting edge
    // itself plus N_RES+1 edges of resolve latency.
    localparam int LAT   = N_RES + 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    csa_accumulator_if #(.WIDTH(WIDTH)) bus ();

    csa_accumulator #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- frame model + monitor ----------------
    typedef struct {
        logic [WIDTH-1:0] data;
        logic             ovf;
        int               acc_cyc;
    } exp_t;

    exp_t             expq[$];
    longint           acc_true = 0;
    bit               prev_valid = 1'b0;
    int               n_out = 0;
    int               last_latency = 0;
    logic [WIDTH-1:0] last_out_data;
    logic [WIDTH-1:0] last_model_data;
    logic             last_model_ovf;

    always @(negedge clk) begin
        if (expq.size() == 0) begin
            check("no_spurious_valid", bus.out_valid, 1'b0);
        end else if (bus.out_valid) begin
            check("mon_out_data", bus.out_data, expq[0].data);
`ifdef CSA_ACC_OVF_EN
            check("mon_out_ovf", bus.out_ovf, expq[0].ovf);
`endif
            if (!prev_valid) begin
                last_latency = cyc - expq[0].acc_cyc;
                check("mon_latency", last_latency, LAT);
            end
        end
        prev_valid = bus.out_valid;

        if (rst) begin
            expq.delete();
            acc_true   = 0;
            prev_valid = 1'b0;
        end else begin
            if (bus.out_valid && bus.out_ready && expq.size() > 0) begin
                last_out_data   = bus.out_data;
                last_model_data = expq[0].data;
                last_model_ovf  = expq[0].ovf;
                void'(expq.pop_front());
                n_out++;
            end
            if (bus.in_valid && bus.in_ready) begin
                exp_t e;
                acc_true += longint'(bus.in_data);
                if (bus.in_last) begin
                    e.data    = acc_true[WIDTH-1:0];
                    e.ovf     = (acc_true >= (64'd1 << WIDTH));
                    e.acc_cyc = cyc;
                    expq.push_back(e);
                    acc_true = 0;
                end
            end
        end
    end

    // ---------------- stimulus helpers (phase: posedge + #1) ----------------
    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input logic [WIDTH-1:0] d, input logic l);
        bit ok = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_last  = l;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
        end
        if (!ok) check("send_ready_timeout", 1'b0, 1'b1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    // Waits for the next output handshake, then pins DUT and model to literals.
    task automatic expect_result(input string name, input logic [WIDTH-1:0] d, input logic o);
        int start = n_out;
        bit got   = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (n_out != start) begin
                got = 1'b1;
                break;
            end
        end
        check({name, "_handshake"}, got, 1'b1);
        if (got) begin
            check({name, "_dut_data"}, last_out_data, d);
            check({name, "_model_data"}, last_model_data, d);
            check({name, "_model_ovf"}, last_model_ovf, o);
        end
        @(posedge clk);
        #1;
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        bit seen;
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        @(negedge clk);
        check("rst_in_ready", bus.in_ready, 1'b1);
        check("rst_out_valid", bus.out_valid, 1'b0);
        check("rst_busy", bus.busy, 1'b0);
        check("rst_out_data", bus.out_data, 8'h00);
        @(posedge clk);
        #1;

        // Contiguous three-beat frame.
        send(8'h03, 1'b0);
        send(8'h05, 1'b0);
        send(8'h07, 1'b1);
        expect_result("t1", 8'h0F, 1'b0);
        check("t1_latency", last_latency, 4);
        @(negedge clk);
        check("t1_pulse", bus.out_valid, 1'b0);
        @(posedge clk);
        #1;

        // Single-beat frames; second confirms S/C were cleared.
        send(8'hA5, 1'b1);
        expect_result("t2a", 8'hA5, 1'b0);
        send(8'h01, 1'b1);
        expect_result("t2b", 8'h01, 1'b0);

        // Carry chain wrapping to zero, and a no-overflow all-ones result.
        send(8'h0F, 1'b0);
        send(8'h01, 1'b0);
        send(8'hF0, 1'b1);
        expect_result("t3a", 8'h00, 1'b1);
        send(8'h80, 1'b0);
        send(8'h7F, 1'b1);
        expect_result("t3b", 8'hFF, 1'b0);

        // Backpressure in DONE with a pending operand that must not be taken.
        bus.out_ready = 1'b0;
        send(8'h12, 1'b0);
        send(8'h34, 1'b1);
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.out_valid) begin
                seen = 1'b1;
                break;
            end
        end
        check("t4_valid_seen", seen, 1'b1);
        bus.in_valid = 1'b1;
        bus.in_data  = 8'h55;
        bus.in_last  = 1'b1;
        repeat (5) begin
            @(negedge clk);
            check("t4_hold_valid", bus.out_valid, 1'b1);
            check("t4_hold_data", bus.out_data, 8'h46);
            check("t4_hold_in_ready", bus.in_ready, 1'b0);
            check("t4_hold_busy", bus.busy, 1'b1);
        end
        @(posedge clk);
        #1 bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        @(negedge clk);
        check("t4_in_ready_after", bus.in_ready, 1'b1);
        check("t4_valid_after", bus.out_valid, 1'b0);
        check("t4_result", last_out_data, 8'h46);
        @(posedge clk);
        #1;
        send(8'h01, 1'b1);
        expect_result("t4_next", 8'h01, 1'b0);

        // Reset mid-frame discards the partial sum.
        send(8'h10, 1'b0);
        send(8'h20, 1'b0);
        @(negedge clk);
        check("t5_busy_partial", bus.busy, 1'b1);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("t5_busy_after_rst", bus.busy, 1'b0);
        check("t5_in_ready_after_rst", bus.in_ready, 1'b1);
        @(posedge clk);
        #1;
        send(8'h01, 1'b1);
        expect_result("t5", 8'h01, 1'b0);

        // Random in_valid gaps.
        send(8'h11, 1'b0);
        idle($urandom_range(0, 3));
        send(8'h22, 1'b0);
        idle($urandom_range(0, 3));
        send(8'h33, 1'b0);
        idle($urandom_range(0, 3));
        send(8'h44, 1'b1);
        expect_result("t6", 8'hAA, 1'b0);
        check("t6_latency", last_latency, 4);

        // Reset during RESOLVE: no output for the aborted frame.
        send(8'h05, 1'b1);
        idle(1);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (8) begin
            @(negedge clk);
            check("t6_abort_valid", bus.out_valid, 1'b0);
        end
        @(posedge clk);
        #1;
        send(8'h5A, 1'b1);
        expect_result("t6_recover", 8'h5A, 1'b0);

        idle(2);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
